controlador_disco: RTL and testbench
====================================

Name: controlador_disco

Overview:
- Boot/load controller that sequences the read-only disk ROM (word-addressed, 26-bit address, 32-bit combinational data) to copy a block of program words into instruction memory.
- Sits between the CPU/OS control logic (issues load requests) and the disk plus the instruction-memory write port.
- One word per transfer step; start/busy/done handshake; detects out-of-range requests; supports abort.

Parameters:
- DISK_SIZE, 16, number of valid disk words; addresses >= DISK_SIZE are out of range.
- DISK_LATENCY, 1, cycles disk_addr is held before disk_data is sampled (>=1).
- MEM_ADDR_W, 10, instruction-memory address width.
- LEN_W, 16, width of the transfer length and word counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; returns the block to IDLE.
- start  input  1  request pulse; sampled only in IDLE.
- src_base  input  26  first disk word address.
- dst_base  input  MEM_ADDR_W  first instruction-memory address.
- length  input  LEN_W  number of words to copy.
- abort  input  1  cancel the active transfer.
- disk_addr  output  26  address to disk.
- disk_data  input  32  disk word (combinational from disk_addr).
- mem_addr  output  MEM_ADDR_W  instruction-memory write address.
- mem_data  output  32  instruction-memory write data.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- busy  output  1  high from the cycle after an accepted start until the cycle before IDLE.
- done  output  1  one-cycle completion pulse.
- error  output  1  qualifies done; high for the same cycle when the request was rejected.
- words_copied  output  LEN_W  count of words written in the current/last transfer.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, including words_copied and disk_addr. Internal base, length and data registers are cleared.
- Request acceptance:
  - In IDLE, start=1 latches src_base, dst_base and length, and clears words_copied.
  - length=0 -> DONE next cycle: done=1, error=0, no mem_we.
  - src_base+length > DISK_SIZE (27-bit compare, no wrap) -> DONE with error=1, no writes.
  - Otherwise -> READ.
- start outside IDLE is ignored.
- States: IDLE, READ, WRITE, DONE.
- READ:
  - disk_addr = src_base + words_copied.
  - A latency counter runs DISK_LATENCY cycles; on the last cycle disk_data is registered into mem_data -> WRITE.
- WRITE (exactly 1 cycle):
  - mem_we=1 and mem_addr = dst_base + words_copied (mod 2^MEM_ADDR_W; wrap is allowed, not an error).
  - words_copied increments at the end of the cycle.
  - If new count == length -> DONE, else -> READ.
- DONE (1 cycle): done=1, error as latched -> IDLE. words_copied holds its value until the next accepted start.
- Throughput: DISK_LATENCY+1 cycles per word. First mem_we comes DISK_LATENCY+1 cycles after the start edge.
- busy=1 in READ and WRITE; busy=0 in IDLE and DONE.
- abort:
  - In READ or WRITE -> IDLE next edge, with no done pulse.
  - If it coincides with a WRITE cycle, that write still occurs (mem_we=1 that cycle) and is counted.
  - Ignored in IDLE and DONE.
- mem_we is only ever asserted in WRITE; mem_addr/mem_data hold their last values otherwise.
- disk_addr holds its last value outside READ.

Decomposition:
- Shared package: state encoding typedef (IDLE, READ, WRITE, DONE) and the disk address width constant (26), shared with the disk ROM and PC.
- One natural sub-module: contador_latencia, a loadable down-counter producing a "ready" pulse after DISK_LATENCY cycles. Everything else lives in the top FSM.

Test Plan:
- src=1, dst=0x20, len=3, DISK_LATENCY=1 -> mem_we pulses at cycles 2, 4, 6 after start, with addr 0x20/0x21/0x22 and data disk[1..3]; done at cycle 7, error=0, words_copied=3.
- len=0 -> done=1 on the cycle after start, error=0, mem_we never asserted, busy stays 0.
- src=14, len=3 (14+3 > 16) -> done with error=1 the cycle after start, no writes, words_copied=0.
- src=0, len=16, dst=0x3FE -> 16 writes; mem_addr wraps 0x3FF -> 0x000; the last word equals the halt instruction; done with error=0.
- Abort during the 2nd READ of len=5 -> exactly 1 write, no done pulse, IDLE next cycle, busy=0, words_copied=1. Repeat with abort coinciding with the 2nd WRITE -> 2 writes.
- Reset asserted mid-WRITE (asynchronous, between edges) -> mem_we, busy, done and words_copied drop to 0 immediately. After release, a new start len=1 completes normally.

Source files
------------

// File: rtl/controlador_disco_pkg.sv
// Shared definitions for the disk boot/load controller.
// Holds the controller state encoding and the disk address/data widths that
// are also used by the disk ROM and the PC, plus the range-check helper.
package controlador_disco_pkg;

    localparam int DISK_ADDR_W = 26;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } estado_t;

    // True when base+len runs past the disk end. The sum is one bit wider
    // than the address, so a request near the top of the space cannot wrap.
    function automatic logic fuera_de_rango(
        input logic [DISK_ADDR_W-1:0] base,
        input logic [DISK_ADDR_W-1:0] len_ext,
        input logic [DISK_ADDR_W:0]   size
    );
        return ({1'b0, base} + {1'b0, len_ext}) > size;
    endfunction

endpackage

// File: rtl/controlador_disco_if.sv
// Bus bundle between the load controller, its requester (CPU/OS), the disk
// ROM and the instruction-memory write port.
//   master : requester/disk side  (drives start, bases, length, abort, disk_data)
//   slave  : controller side      (drives disk_addr, mem_*, busy, done, error,
//                                   words_copied)
interface controlador_disco_if #(
    parameter int MEM_ADDR_W = 10,
    parameter int LEN_W      = 16
);
    import controlador_disco_pkg::*;

    logic                   start;
    logic [DISK_ADDR_W-1:0] src_base;
    logic [MEM_ADDR_W-1:0]  dst_base;
    logic [LEN_W-1:0]       length;
    logic                   abort;
    logic [DISK_ADDR_W-1:0] disk_addr;
    logic [DATA_W-1:0]      disk_data;
    logic [MEM_ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]      mem_data;
    logic                   mem_we;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [LEN_W-1:0]       words_copied;

    modport master (
        output start, src_base, dst_base, length, abort, disk_data,
        input  disk_addr, mem_addr, mem_data, mem_we, busy, done, error, words_copied
    );

    modport slave (
        input  start, src_base, dst_base, length, abort, disk_data,
        output disk_addr, mem_addr, mem_data, mem_we, busy, done, error, words_copied
    );

endinterface

// File: rtl/controlador_disco_contador_latencia.sv
// Loadable down-counter that times the disk access.
// Ports: clock_i/reset_i (async active-high), load_i reloads LATENCY-1,
// en_i counts down while the access is in progress, ready_o is high on the
// last cycle of the access (combinational from the count).
module contador_latencia #(
    parameter int LATENCY = 1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic en_i,
    output logic ready_o
);

    localparam int              CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CARGA = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign ready_o = en_i && (cnt_q == {CNT_W{1'b0}});

    // Next count: reload on a new access, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CARGA;
        end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/controlador_disco.sv
// Boot/load controller: copies `length` words from the disk ROM, starting at
// src_base, into instruction memory starting at dst_base, one word per
// DISK_LATENCY+1 cycles.
// Ports: clock, reset (async active-high), bus (slave side of
// controlador_disco_if: request/abort in, disk address out / data in,
// instruction-memory write port and busy/done/error/words_copied status out).
// All bus outputs are registered.
module controlador_disco
    import controlador_disco_pkg::*;
#(
    parameter int DISK_SIZE    = 16,
    parameter int DISK_LATENCY = 1,
    parameter int MEM_ADDR_W   = 10,
    parameter int LEN_W        = 16
) (
    input  logic                clock,
    input  logic                reset,
    controlador_disco_if.slave  bus
);

    localparam int                  AW        = DISK_ADDR_W;
    localparam logic [AW:0]         SIZE_EXT  = DISK_SIZE[AW:0];
    localparam logic [LEN_W-1:0]    UNO       = {{(LEN_W-1){1'b0}}, 1'b1};

    estado_t                state_q, state_d;
    logic [AW-1:0]          src_q, src_d;
    logic [MEM_ADDR_W-1:0]  dst_q, dst_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       wc_q, wc_d;
    logic                   rechazo_q, rechazo_d;

    logic [AW-1:0]          disk_addr_q, disk_addr_d;
    logic [MEM_ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_data_q, mem_data_d;
    logic                   mem_we_q, mem_we_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic                   lat_load_s;
    logic                   lat_ready_s;

    // Reload the latency counter on every entry into READ.
    assign lat_load_s = (state_d == ST_READ) && (state_q != ST_READ);

    contador_latencia #(
        .LATENCY (DISK_LATENCY)
    ) u_contador_latencia (
        .clock_i (clock),
        .reset_i (reset),
        .load_i  (lat_load_s),
        .en_i    (state_q == ST_READ),
        .ready_o (lat_ready_s)
    );

    // State register and request/progress registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            src_q     <= {AW{1'b0}};
            dst_q     <= {MEM_ADDR_W{1'b0}};
            len_q     <= {LEN_W{1'b0}};
            wc_q      <= {LEN_W{1'b0}};
            rechazo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            wc_q      <= wc_d;
            rechazo_q <= rechazo_d;
        end
    end

    // Next-state logic: request acceptance, per-word sequencing and abort.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        wc_d      = wc_q;
        rechazo_d = rechazo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    src_d     = bus.src_base;
                    dst_d     = bus.dst_base;
                    len_d     = bus.length;
                    wc_d      = {LEN_W{1'b0}};
                    rechazo_d = 1'b0;
                    if (bus.length == {LEN_W{1'b0}}) begin
                        state_d = ST_DONE;
                    end else if (fuera_de_rango(bus.src_base, AW'(bus.length), SIZE_EXT)) begin
                        rechazo_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (lat_ready_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                // The write in this cycle always lands, even when aborted.
                wc_d = wc_q + UNO;
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if ((wc_q + UNO) == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values, derived from the state being entered so that the
    // registered outputs line up with that state.
    always_comb begin
        busy_d      = (state_d == ST_READ) || (state_d == ST_WRITE);
        mem_we_d    = (state_d == ST_WRITE);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_DONE) && rechazo_d;
        disk_addr_d = (state_d == ST_READ)
                      ? (src_d + {{(AW-LEN_W){1'b0}}, wc_d})
                      : disk_addr_q;
        // Destination address wraps modulo the memory size by truncation.
        mem_addr_d  = (state_d == ST_WRITE)
                      ? (dst_q + MEM_ADDR_W'(wc_q))
                      : mem_addr_q;
        mem_data_d  = (state_d == ST_WRITE) ? bus.disk_data : mem_data_q;
    end

    // Output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            disk_addr_q <= {AW{1'b0}};
            mem_addr_q  <= {MEM_ADDR_W{1'b0}};
            mem_data_q  <= {DATA_W{1'b0}};
        end else begin
            busy_q      <= busy_d;
            mem_we_q    <= mem_we_d;
            done_q      <= done_d;
            error_q     <= error_d;
            disk_addr_q <= disk_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.disk_addr    = disk_addr_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data     = mem_data_q;
    assign bus.words_copied = wc_q;

endmodule

// File: tb/tb_controlador_disco.sv
// Scoreboard bench for controlador_disco: each request pushes its expected
// writes/done (with their cycle offsets) into a queue; a monitor pops and
// compares whenever the DUT pulses mem_we or done.
module tb_controlador_disco;
    import controlador_disco_pkg::*;

    localparam int          LAT       = 1;
    localparam int          DS        = 16;
    localparam int          MAW       = 10;
    localparam int          LW        = 16;
    localparam int          STEP      = LAT + 1;
    localparam logic [31:0] HALT_INSN = 32'h0000_006F;

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [9:0]  addr;
        logic [31:0] data;
        bit          err;
        int          wc;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    controlador_disco_if #(.MEM_ADDR_W(MAW), .LEN_W(LW)) bus();

    controlador_disco #(
        .DISK_SIZE(DS), .DISK_LATENCY(LAT), .MEM_ADDR_W(MAW), .LEN_W(LW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] rom [DS];
    assign bus.disk_data = (bus.disk_addr < 26'(DS)) ? rom[bus.disk_addr[3:0]] : 32'hDEAD_BEEF;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  start_edge = 0;
    ev_t mon_e;
    int  mon_rel;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every write or done pulse must match the head of the queue.
    always @(negedge clock) begin
        if (reset === 1'b0 && (bus.mem_we === 1'b1 || bus.done === 1'b1)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {62'd0, bus.mem_we, bus.done}, 64'd0);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_rel = cyc - start_edge;
                chk("event_kind", bus.done, mon_e.is_done);
                chk("event_cycle", mon_rel, mon_e.cyc);
                if (mon_e.is_done) begin
                    chk("done_error", bus.error, mon_e.err);
                    chk("done_words", bus.words_copied, mon_e.wc);
                end else begin
                    chk("write_addr", bus.mem_addr, mon_e.addr);
                    chk("write_data", bus.mem_data, mon_e.data);
                end
            end
        end
    end

    // One request; abort_c>0 raises abort during that cycle after the start edge.
    task automatic xfer(input int src, input int dst, input int len, input int abort_c);
        bit accepted, aborted;
        int n, last_active, total, exp_wc;
        @(negedge clock);
        accepted = (len != 0) && (src + len <= DS);
        aborted  = accepted && (abort_c > 0) && (abort_c <= STEP * len);
        if (!accepted) begin
            exp_q.push_back('{is_done: 1'b1, cyc: 1, addr: 10'd0, data: 32'd0,
                              err: (len != 0), wc: 0});
            exp_wc = 0; last_active = 0; total = 1;
        end else begin
            n = aborted ? (abort_c / STEP) : len;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back('{is_done: 1'b0, cyc: STEP * (i + 1),
                                  addr: 10'((dst + i) % 1024), data: rom[src + i],
                                  err: 1'b0, wc: 0});
            end
            if (!aborted) begin
                exp_q.push_back('{is_done: 1'b1, cyc: STEP * len + 1, addr: 10'd0,
                                  data: 32'd0, err: 1'b0, wc: len});
            end
            exp_wc      = n;
            last_active = aborted ? abort_c : STEP * len;
            total       = aborted ? abort_c + 1 : STEP * len + 1;
        end
        bus.src_base = 26'(src);
        bus.dst_base = 10'(dst);
        bus.length   = 16'(len);
        bus.start    = 1'b1;
        start_edge   = cyc;
        for (int c = 1; c <= total + 2; c++) begin
            @(negedge clock);
            if (c == 1) bus.start = 1'b0;
            bus.abort = (c == abort_c) ? 1'b1 : 1'b0;
            chk("busy", bus.busy, (c <= last_active) ? 64'd1 : 64'd0);
        end
        bus.abort = 1'b0;
        chk("queue_drained", exp_q.size(), 64'd0);
        chk("words_copied", bus.words_copied, exp_wc);
    endtask

    // Asynchronous reset between edges while a WRITE is on the bus.
    task automatic reset_mid_write();
        @(negedge clock);
        exp_q.push_back('{is_done: 1'b0, cyc: STEP, addr: 10'h050, data: rom[3],
                          err: 1'b0, wc: 0});
        bus.src_base = 26'd3;
        bus.dst_base = 10'h050;
        bus.length   = 16'd3;
        bus.start    = 1'b1;
        start_edge   = cyc;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (STEP - 1) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_mem_we", bus.mem_we, 64'd0);
        chk("rst_async_busy", bus.busy, 64'd0);
        chk("rst_async_done", bus.done, 64'd0);
        chk("rst_async_words", bus.words_copied, 64'd0);
        chk("rst_queue", exp_q.size(), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        xfer(5, 'h007, 1, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int src, dst, len, ab;
        for (int i = 0; i < DS; i++) rom[i] = $urandom;
        rom[DS-1] = HALT_INSN;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.src_base = 26'd0; bus.dst_base = 10'd0; bus.length = 16'd0;

        #12;
        chk("rst_busy", bus.busy, 64'd0);
        chk("rst_mem_we", bus.mem_we, 64'd0);
        chk("rst_done", bus.done, 64'd0);
        chk("rst_error", bus.error, 64'd0);
        chk("rst_words", bus.words_copied, 64'd0);
        chk("rst_disk_addr", bus.disk_addr, 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_mem_data", bus.mem_data, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        xfer(1, 'h020, 3, 0);       // basic three-word copy
        xfer(0, 'h020, 0, 0);       // empty request
        xfer(14, 'h000, 3, 0);      // out of range, rejected
        xfer(0, 'h3FE, 16, 0);      // whole disk, destination wraps, ends on halt
        xfer(2, 'h100, 5, STEP + 1);    // abort in 2nd READ
        xfer(2, 'h100, 5, 2 * STEP);    // abort in 2nd WRITE
        xfer(16, 'h000, 1, 0);      // first address past the end
        xfer(15, 'h3FF, 1, 0);      // last disk word only
        reset_mid_write();

        for (int k = 0; k < 40; k++) begin
            src = $urandom_range(0, 17);
            len = $urandom_range(0, 7);
            dst = $urandom_range(0, 1023);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, STEP * len + 2) : 0;
            xfer(src, dst, len, ab);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
